// File: rtl/vga_pkg.sv
// Shared types, standard modes and helper functions for the VGA raster timing generator.
package vga_pkg;

  localparam int unsigned VGA_CW = 12;

  typedef logic [VGA_CW-1:0] vga_field_t;
  // Four CW-bit fields can sum to almost 2^(CW+2); two guard bits keep oversize
  // configs from wrapping back into the legal range.
  typedef logic [VGA_CW+1:0] vga_sum_t;

  typedef struct packed {
    vga_field_t hactive;
    vga_field_t hfp;
    vga_field_t hsyn;
    vga_field_t hbp;
    vga_field_t vactive;
    vga_field_t vfp;
    vga_field_t vsyn;
    vga_field_t vbp;
  } vga_timing_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic sync_b;
    logic blank_b;
    logic line_start;
    logic frame_start;
  } vga_sync_t;

  typedef enum logic {
    CFG_IDLE,
    CFG_PENDING
  } vga_cfg_state_e;

  function automatic vga_timing_t vga_mode(input int unsigned ha, hf, hs, hb,
                                           input int unsigned va, vf, vs, vb);
    vga_timing_t t;
    t.hactive = vga_field_t'(ha);
    t.hfp     = vga_field_t'(hf);
    t.hsyn    = vga_field_t'(hs);
    t.hbp     = vga_field_t'(hb);
    t.vactive = vga_field_t'(va);
    t.vfp     = vga_field_t'(vf);
    t.vsyn    = vga_field_t'(vs);
    t.vbp     = vga_field_t'(vb);
    return t;
  endfunction

  function automatic vga_sum_t vga_total(input vga_field_t a, b, c, d);
    return vga_sum_t'(a) + vga_sum_t'(b) + vga_sum_t'(c) + vga_sum_t'(d);
  endfunction

  function automatic logic vga_timing_ok(input vga_timing_t t);
    vga_sum_t htot;
    vga_sum_t vtot;
    logic     nonzero;
    htot    = vga_total(t.hactive, t.hfp, t.hsyn, t.hbp);
    vtot    = vga_total(t.vactive, t.vfp, t.vsyn, t.vbp);
    nonzero = (t.hactive != '0) && (t.hfp != '0) && (t.hsyn != '0) && (t.hbp != '0) &&
              (t.vactive != '0) && (t.vfp != '0) && (t.vsyn != '0) && (t.vbp != '0);
    return nonzero && (htot[VGA_CW+1:VGA_CW] == '0) && (vtot[VGA_CW+1:VGA_CW] == '0);
  endfunction

  localparam vga_timing_t VGA_640X480 = vga_mode(640, 16, 96, 48, 480, 10, 2, 33);
  localparam vga_timing_t VGA_800X600 = vga_mode(800, 40, 128, 88, 600, 1, 4, 23);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Configuration handshake between the mode-setting master and the timing generator.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic        cfg_valid;
  vga_timing_t cfg_timing;
  logic        cfg_ready;
  logic        cfg_err;

  modport master (output cfg_valid, output cfg_timing, input cfg_ready, input cfg_err);
  modport slave  (input cfg_valid, input cfg_timing, output cfg_ready, output cfg_err);
endinterface

// File: rtl/vga_sync_delay.sv
// DEPTH-stage register chain aligning sync/strobe outputs with downstream pixel latency.
module vga_sync_delay #(
  parameter int unsigned    DEPTH   = 0,
  parameter int unsigned    W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         vgaclk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = vgaclk ^ reset;
    assign q = d;
  end else begin : g_chain
    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge vgaclk or negedge reset) begin
      if (!reset) begin
        for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else begin
        stage[0] <= d;
        for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Runtime-reprogrammable VGA raster timing generator: h/v counters, region decode,
// optional output delay, and a shadowed config that goes live only at the frame wrap.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CW         = VGA_CW,
  parameter int unsigned PIPE_DLY   = 0,
  parameter logic        HS_POL     = 1'b0,
  parameter logic        VS_POL     = 1'b0,
  parameter vga_timing_t DEF_TIMING = VGA_640X480
) (
  input  logic            vgaclk,
  input  logic            reset,
  vga_timing_gen_if.slave cfg,
  output logic            hsync,
  output logic            vsync,
  output logic            sync_b,
  output logic            blank_b,
  output logic            de,
  output logic            line_start,
  output logic            frame_start,
  output logic [CW-1:0]   hcnt,
  output logic [CW-1:0]   vcnt
);

  if (CW != VGA_CW) begin : g_cw_check
    $error("vga_timing_gen: CW must equal vga_pkg::VGA_CW");
  end
  if (PIPE_DLY > 15) begin : g_dly_check
    $error("vga_timing_gen: PIPE_DLY must be 0..15");
  end

  localparam vga_sync_t SYNC_RST = '{hsync: ~HS_POL, vsync: ~VS_POL, sync_b: 1'b1, default: 1'b0};

  vga_timing_t    live_q, shadow_q;
  vga_cfg_state_e state_q, state_d;
  logic           shadow_ld, live_ld, err_d, err_q;

  logic [CW-1:0]  hcnt_q, vcnt_q, hlast, vlast;
  logic           hwrap, fwrap;

  assign hlast = CW'(vga_total(live_q.hactive, live_q.hfp, live_q.hsyn, live_q.hbp) - vga_sum_t'(1));
  assign vlast = CW'(vga_total(live_q.vactive, live_q.vfp, live_q.vsyn, live_q.vbp) - vga_sum_t'(1));
  assign hwrap = (hcnt_q == hlast);
  assign fwrap = hwrap && (vcnt_q == vlast);

  always_ff @(posedge vgaclk or negedge reset) begin
    if (!reset) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else if (hwrap) begin
      hcnt_q <= '0;
      vcnt_q <= fwrap ? '0 : vcnt_q + CW'(1);
    end else begin
      hcnt_q <= hcnt_q + CW'(1);
    end
  end

  always_ff @(posedge vgaclk or negedge reset) begin
    if (!reset) begin
      state_q  <= CFG_IDLE;
      live_q   <= DEF_TIMING;
      shadow_q <= DEF_TIMING;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (shadow_ld) shadow_q <= cfg.cfg_timing;
      if (live_ld)   live_q   <= shadow_q;
    end
  end

  // A config accepted on the wrap cycle is still IDLE there, so it waits a full frame.
  always_comb begin
    state_d       = state_q;
    shadow_ld     = 1'b0;
    live_ld       = 1'b0;
    err_d         = 1'b0;
    cfg.cfg_ready = 1'b0;
    case (state_q)
      CFG_IDLE: begin
        cfg.cfg_ready = 1'b1;
        if (cfg.cfg_valid) begin
          if (vga_timing_ok(cfg.cfg_timing)) begin
            shadow_ld = 1'b1;
            state_d   = CFG_PENDING;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CFG_PENDING: begin
        if (fwrap) begin
          live_ld = 1'b1;
          state_d = CFG_IDLE;
        end
      end
      default: state_d = CFG_IDLE;
    endcase
  end

  assign cfg.cfg_err = err_q;

  logic [CW:0] hs_beg, hs_end, vs_beg, vs_end;
  logic        h_act, v_act, h_syn, v_syn;

  assign hs_beg = {1'b0, live_q.hactive} + {1'b0, live_q.hfp};
  assign hs_end = hs_beg + {1'b0, live_q.hsyn};
  assign vs_beg = {1'b0, live_q.vactive} + {1'b0, live_q.vfp};
  assign vs_end = vs_beg + {1'b0, live_q.vsyn};

  assign h_act = hcnt_q < live_q.hactive;
  assign v_act = vcnt_q < live_q.vactive;
  assign h_syn = ({1'b0, hcnt_q} >= hs_beg) && ({1'b0, hcnt_q} < hs_end);
  assign v_syn = ({1'b0, vcnt_q} >= vs_beg) && ({1'b0, vcnt_q} < vs_end);

  vga_sync_t dec_d, dec_q, dly_q;

  always_comb begin
    dec_d             = SYNC_RST;
    dec_d.hsync       = h_syn ? HS_POL : ~HS_POL;
    dec_d.vsync       = v_syn ? VS_POL : ~VS_POL;
    dec_d.sync_b      = ~(h_syn | v_syn);
    dec_d.blank_b     = h_act & v_act;
    dec_d.line_start  = (hcnt_q == '0);
    dec_d.frame_start = (hcnt_q == '0) && (vcnt_q == '0);
  end

  always_ff @(posedge vgaclk or negedge reset) begin
    if (!reset) dec_q <= SYNC_RST;
    else        dec_q <= dec_d;
  end

  vga_sync_delay #(
    .DEPTH   (PIPE_DLY),
    .W       ($bits(vga_sync_t)),
    .RST_VAL (SYNC_RST)
  ) u_sync_delay (
    .vgaclk (vgaclk),
    .reset  (reset),
    .d      (dec_q),
    .q      (dly_q)
  );

  assign hsync       = dly_q.hsync;
  assign vsync       = dly_q.vsync;
  assign sync_b      = dly_q.sync_b;
  assign blank_b     = dly_q.blank_b;
  assign de          = dly_q.blank_b;
  assign line_start  = dly_q.line_start;
  assign frame_start = dly_q.frame_start;
  assign hcnt        = hcnt_q;
  assign vcnt        = vcnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: frame-position reference model checked every cycle,
// plus literal measurements of periods, pulse widths and reconfiguration timing.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int unsigned D  = 3;
  localparam logic        HP = 1'b1;
  localparam logic        VP = 1'b0;
  localparam vga_timing_t MINI = vga_mode(16, 2, 4, 3, 5, 1, 2, 2);  // 25 x 10
  localparam vga_timing_t W2   = vga_mode(10, 1, 2, 1, 4, 1, 1, 1);  // 14 x 7

  logic        vgaclk = 1'b0;
  logic        reset  = 1'b0;
  logic        hsync, vsync, sync_b, blank_b, de, line_start, frame_start;
  logic [11:0] hcnt, vcnt;

  vga_timing_gen_if cfg_if ();

  vga_timing_gen #(
    .CW         (12),
    .PIPE_DLY   (D),
    .HS_POL     (HP),
    .VS_POL     (VP),
    .DEF_TIMING (MINI)
  ) dut (
    .vgaclk      (vgaclk),
    .reset       (reset),
    .cfg         (cfg_if.slave),
    .hsync       (hsync),
    .vsync       (vsync),
    .sync_b      (sync_b),
    .blank_b     (blank_b),
    .de          (de),
    .line_start  (line_start),
    .frame_start (frame_start),
    .hcnt        (hcnt),
    .vcnt        (vcnt)
  );

  always #5 vgaclk = ~vgaclk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic hsync, vsync, sync_b, blank_b, line_start, frame_start;
  } exp_t;

  localparam exp_t M_RST = '{hsync: ~HP, vsync: ~VP, sync_b: 1'b1, default: 1'b0};

  vga_timing_t m_live   = MINI;
  vga_timing_t m_shadow = MINI;
  bit          m_pend   = 1'b0;
  bit          m_err    = 1'b0;
  int unsigned m_t      = 0;   // cycles elapsed since the current frame began
  exp_t        m_q[$];

  function automatic int unsigned tot_h(input vga_timing_t t);
    return int'(t.hactive) + int'(t.hfp) + int'(t.hsyn) + int'(t.hbp);
  endfunction

  function automatic int unsigned tot_v(input vga_timing_t t);
    return int'(t.vactive) + int'(t.vfp) + int'(t.vsyn) + int'(t.vbp);
  endfunction

  function automatic bit legal(input vga_timing_t t);
    return t.hactive != 0 && t.hfp != 0 && t.hsyn != 0 && t.hbp != 0 &&
           t.vactive != 0 && t.vfp != 0 && t.vsyn != 0 && t.vbp != 0 &&
           tot_h(t) < 4096 && tot_v(t) < 4096;
  endfunction

  function automatic exp_t decode(input int unsigned h, input int unsigned v, input vga_timing_t t);
    exp_t        e;
    int unsigned hs0, vs0;
    bit          hin, vin;
    hs0 = int'(t.hactive) + int'(t.hfp);
    vs0 = int'(t.vactive) + int'(t.vfp);
    hin = (h >= hs0) && (h < hs0 + int'(t.hsyn));
    vin = (v >= vs0) && (v < vs0 + int'(t.vsyn));
    e.hsync       = hin ? HP : ~HP;
    e.vsync       = vin ? VP : ~VP;
    e.sync_b      = !hin && !vin;
    e.blank_b     = (h < int'(t.hactive)) && (v < int'(t.vactive));
    e.line_start  = (h == 0);
    e.frame_start = (h == 0) && (v == 0);
    return e;
  endfunction

  task automatic model_reset();
    m_live   = MINI;
    m_shadow = MINI;
    m_pend   = 1'b0;
    m_err    = 1'b0;
    m_t      = 0;
    m_q.delete();
  endtask

  task automatic model_step();
    int unsigned ht, vt;
    bit          was_pend;
    ht       = tot_h(m_live);
    vt       = tot_v(m_live);
    was_pend = m_pend;
    m_q.push_back(decode(m_t % ht, m_t / ht, m_live));
    if (m_q.size() > D + 1) void'(m_q.pop_front());
    m_t++;
    if (m_t == ht * vt) begin
      m_t = 0;
      if (was_pend) begin
        m_live = m_shadow;
        m_pend = 1'b0;
      end
    end
    m_err = 1'b0;
    if (!was_pend && cfg_if.cfg_valid) begin
      if (legal(cfg_if.cfg_timing)) begin
        m_shadow = cfg_if.cfg_timing;
        m_pend   = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  always @(posedge vgaclk or negedge reset) begin
    if (!reset) model_reset();
    else        model_step();
  end

  always @(negedge vgaclk) begin : cmp
    exp_t        e;
    int unsigned ht;
    e  = (m_q.size() == D + 1) ? m_q[0] : M_RST;
    ht = tot_h(m_live);
    check("hcnt",        hcnt,             m_t % ht);
    check("vcnt",        vcnt,             m_t / ht);
    check("hsync",       hsync,            e.hsync);
    check("vsync",       vsync,            e.vsync);
    check("sync_b",      sync_b,           e.sync_b);
    check("blank_b",     blank_b,          e.blank_b);
    check("de",          de,               e.blank_b);
    check("line_start",  line_start,       e.line_start);
    check("frame_start", frame_start,      e.frame_start);
    check("cfg_ready",   cfg_if.cfg_ready, !m_pend);
    check("cfg_err",     cfg_if.cfg_err,   m_err);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge vgaclk);
  endtask

  task automatic offer(input vga_timing_t t);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_timing = t;
    @(negedge vgaclk);
    cfg_if.cfg_valid  = 1'b0;
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return frame_start;
      1:       return line_start;
      default: return cfg_if.cfg_ready;
    endcase
  endfunction

  // Cycles until the selected signal is high; -1 if the bound expires.
  task automatic wait_hi(input int sel, input int bound, output int n);
    n = 0;
    do begin
      @(negedge vgaclk);
      n++;
    end while (!pick(sel) && n < bound);
    if (!pick(sel)) n = -1;
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b0;
    cycles(3);
    #1 reset = 1'b1;
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    vga_timing_t t;
    int          n, p, cnt_b, cnt_h, cnt_v, rise_h, run;
    logic        prev;

    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_timing = MINI;
    cycles(3);

    check("rst hsync",   hsync,            1'b0);
    check("rst vsync",   vsync,            1'b1);
    check("rst sync_b",  sync_b,           1'b1);
    check("rst blank_b", blank_b,          1'b0);
    check("rst frame",   frame_start,      1'b0);
    check("rst ready",   cfg_if.cfg_ready, 1'b1);
    check("rst hcnt",    hcnt,             0);
    check("pkg 640 htot", 32'(vga_total(VGA_640X480.hactive, VGA_640X480.hfp, VGA_640X480.hsyn, VGA_640X480.hbp)), 800);
    check("pkg 640 vtot", 32'(vga_total(VGA_640X480.vactive, VGA_640X480.vfp, VGA_640X480.vsyn, VGA_640X480.vbp)), 525);
    check("pkg 800 htot", 32'(vga_total(VGA_800X600.hactive, VGA_800X600.hfp, VGA_800X600.hsyn, VGA_800X600.hbp)), 1056);
    check("pkg 800 vtot", 32'(vga_total(VGA_800X600.vactive, VGA_800X600.vfp, VGA_800X600.vsyn, VGA_800X600.vbp)), 628);

    #1 reset = 1'b1;
    wait_hi(0, 20, n);
    check("first frame_start cycle", n, 1 + D);
    wait_hi(0, 400, p);
    check("mini frame period", p, 250);

    cnt_b = 0; cnt_h = 0; cnt_v = 0;
    repeat (250) begin
      @(negedge vgaclk);
      if (blank_b) cnt_b++;
      if (hsync == HP) cnt_h++;
      if (vsync == VP) cnt_v++;
    end
    check("mini blank per frame", cnt_b, 80);
    check("mini hsync per frame", cnt_h, 40);
    check("mini vsync per frame", cnt_v, 50);

    t = VGA_800X600; t.hsyn = '0;
    offer(t);
    check("err hsyn0 pulse", cfg_if.cfg_err,   1'b1);
    check("err hsyn0 ready", cfg_if.cfg_ready, 1'b1);
    t = VGA_800X600; t.hactive = 12'd4000;
    offer(t);
    check("err wide pulse", cfg_if.cfg_err,   1'b1);
    check("err wide ready", cfg_if.cfg_ready, 1'b1);
    cycles(1);
    check("err one cycle", cfg_if.cfg_err, 1'b0);
    wait_hi(0, 400, n);
    wait_hi(0, 400, p);
    check("timing unchanged after err", p, 250);

    // offer on the exact wrap cycle: one more old frame, then W2
    for (int k = 0; k < 300; k++) begin
      @(negedge vgaclk);
      if (hcnt == 12'd24 && vcnt == 12'd9) break;
    end
    offer(W2);
    wait_hi(0, 20, n);
    wait_hi(0, 400, p);
    check("wrap offer old frame", p, 250);
    wait_hi(0, 400, p);
    check("wrap offer new frame", p, 98);

    for (int i = 0; i < 25; i++) begin
      cycles($urandom_range(0, 200));
      t = vga_mode($urandom_range(1, 8), $urandom_range(1, 8), $urandom_range(1, 8), $urandom_range(1, 8),
                   $urandom_range(1, 8), $urandom_range(1, 8), $urandom_range(1, 8), $urandom_range(1, 8));
      case ($urandom_range(0, 5))
        0:       t.vbp     = '0;
        1:       t.hactive = 12'd4094;
        2:       t.vactive = 12'd4094;
        default: ;
      endcase
      offer(t);
    end

    pulse_reset();
    cycles(37);
    offer(VGA_800X600);
    check("800 ready drops", cfg_if.cfg_ready, 1'b0);
    wait_hi(2, 400, n);
    check("800 ready returns", n > 0, 1'b1);
    check("800 live at hcnt 0", hcnt, 0);
    check("800 live at vcnt 0", vcnt, 0);
    wait_hi(1, 20, n);
    wait_hi(1, 1200, p);
    check("800 line period", p, 1056);
    cnt_h = 0;
    repeat (1056) begin
      @(negedge vgaclk);
      if (hsync == HP) cnt_h++;
    end
    check("800 hsync per line", cnt_h, 128);

    offer(VGA_640X480);
    check("pending before reset", cfg_if.cfg_ready, 1'b0);
    cycles(50);
    #1 reset = 1'b0;
    @(negedge vgaclk);
    check("mid-pending rst hcnt",  hcnt,             0);
    check("mid-pending rst ready", cfg_if.cfg_ready, 1'b1);
    check("mid-pending rst hsync", hsync,            1'b0);
    check("mid-pending rst blank", blank_b,          1'b0);
    cycles(2);
    #1 reset = 1'b1;
    wait_hi(0, 20, n);
    check("post-reset first frame", n, 1 + D);
    wait_hi(0, 400, p);
    check("default timing resumes", p, 250);

    offer(VGA_640X480);
    wait_hi(2, 400, n);
    check("640 ready returns", n > 0, 1'b1);
    prev   = hsync;
    rise_h = -1;
    for (int k = 0; k < 1700 && rise_h < 0; k++) begin
      @(negedge vgaclk);
      if (hsync && !prev) rise_h = int'(hcnt);
      prev = hsync;
    end
    check("640 hsync rise hcnt", rise_h, 656 + 1 + D);
    run = 0;
    while (hsync && run < 900) begin
      run++;
      @(negedge vgaclk);
    end
    check("640 hsync width", run, 96);
    for (int k = 0; k < 900 && !blank_b; k++) @(negedge vgaclk);
    run = 0;
    while (blank_b && run < 900) begin
      run++;
      @(negedge vgaclk);
    end
    check("640 blank width", run, 640);

    cycles(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
